// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/squash bus into the hazard scoreboard plus its interlock outputs.
// Stats ports exist only when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = 5
);
    logic                id_valid;
    logic [31:0]         id_instr;
    logic                wb_valid;
    logic [REG_AW-1:0]   wb_rd;
    logic                sq_valid;
    logic [REG_AW-1:0]   sq_rd;
    logic                stall;
    logic                issue;
    logic [NUM_REGS-1:0] busy_mask;
    logic                err_uflow;
`ifdef HAZARD_STATS_EN
    logic [31:0]         stall_cycles;
    logic [31:0]         hazard_events;
`endif

    modport master (
        output id_valid, id_instr, wb_valid, wb_rd, sq_valid, sq_rd,
        input  stall, issue, busy_mask, err_uflow
`ifdef HAZARD_STATS_EN
        , input stall_cycles, hazard_events
`endif
    );

    modport slave (
        input  id_valid, id_instr, wb_valid, wb_rd, sq_valid, sq_rd,
        output stall, issue, busy_mask, err_uflow
`ifdef HAZARD_STATS_EN
        , output stall_cycles, hazard_events
`endif
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW/WAW interlock: per-register in-flight write counters gate decode issue.
// Optional HAZARD_STATS_EN adds stall_cycles / hazard_events counters.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MAX_PENDING = 3,
    parameter int unsigned WB_BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_PENDING + 1);
    localparam int unsigned SW = CW + 2;

    localparam logic [6:0]  OP_LOAD   = 7'h03;
    localparam logic [6:0]  OP_IMM    = 7'h13;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_REG    = 7'h33;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_JAL    = 7'h6F;
    localparam logic [6:0]  OP_LUI    = 7'h37;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic              re1;
        logic              re2;
        logic              we;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } dec_t;

    dec_t              dec;
    logic [CW-1:0]     cnt     [NUM_REGS];
    logic [CW-1:0]     cnt_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic              err_q;
    logic              uflow_hit;
    logic              rel1, rel2, pend1, pend2, full;
    logic              stall_c, issue_c;

    // Register usage by opcode; x0 accesses never count as dependencies.
    always_comb begin
        dec     = '0;
        dec.rd  = REG_AW'(bus.id_instr[11:7]);
        dec.rs1 = REG_AW'(bus.id_instr[19:15]);
        dec.rs2 = REG_AW'(bus.id_instr[24:20]);
        case (bus.id_instr[6:0])
            OP_LOAD, OP_IMM:     begin dec.re1 = 1'b1; dec.we = 1'b1; end
            OP_STORE, OP_BRANCH: begin dec.re1 = 1'b1; dec.re2 = 1'b1; end
            OP_REG:              begin dec.re1 = 1'b1; dec.re2 = 1'b1; dec.we = 1'b1; end
            OP_JAL, OP_LUI:      dec.we = 1'b1;
            default: ;
        endcase
        if (bus.id_instr == INSTR_NOP || bus.id_instr == 32'h0) begin
            dec.re1 = 1'b0;
            dec.re2 = 1'b0;
            dec.we  = 1'b0;
        end
        if (dec.rs1 == '0) dec.re1 = 1'b0;
        if (dec.rs2 == '0) dec.re2 = 1'b0;
        if (dec.rd  == '0) dec.we  = 1'b0;
    end

    // Sources see this cycle's writeback release when bypassing; the WAW limit does not.
    always_comb begin
        rel1    = (WB_BYPASS != 0) && bus.wb_valid && (bus.wb_rd == dec.rs1);
        rel2    = (WB_BYPASS != 0) && bus.wb_valid && (bus.wb_rd == dec.rs2);
        pend1   = cnt[dec.rs1] > CW'(rel1);
        pend2   = cnt[dec.rs2] > CW'(rel2);
        full    = cnt[dec.rd] == CW'(MAX_PENDING);
        stall_c = bus.id_valid && ((dec.re1 && pend1) || (dec.re2 && pend2) || (dec.we && full));
        issue_c = bus.id_valid && !stall_c;
    end

    // Returns {underflow, next count}; saturates at zero.
    function automatic logic [CW:0] cnt_step(input logic [CW-1:0] c, input logic inc,
                                             input logic d_wb, input logic d_sq);
        logic [SW-1:0] up;
        logic [SW-1:0] down;
        up   = SW'(c) + SW'(inc);
        down = SW'(d_wb) + SW'(d_sq);
        if (down > up) return {1'b1, CW'(0)};
        return {1'b0, CW'(up - down)};
    endfunction

    always_comb begin
        uflow_hit = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = '0;
            if (r != 0) begin
                logic [CW:0] res;
                res = cnt_step(cnt[r],
                               issue_c && dec.we && (dec.rd == REG_AW'(r)),
                               bus.wb_valid && (bus.wb_rd == REG_AW'(r)),
                               bus.sq_valid && (bus.sq_rd == REG_AW'(r)));
                cnt_nxt[r] = res[CW-1:0];
                if (res[CW]) uflow_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r]    <= cnt_nxt[r];
                busy_q[r] <= (cnt_nxt[r] != '0);
            end
            err_q <= err_q | uflow_hit;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.issue     = issue_c;
    assign bus.busy_mask = busy_q;
    assign bus.err_uflow = err_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] hazard_events_q;
    logic        stall_prev_q;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q  <= '0;
            hazard_events_q <= '0;
            stall_prev_q    <= 1'b0;
        end else begin
            stall_prev_q <= stall_c;
            if (stall_c) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (stall_c && !stall_prev_q) hazard_events_q <= hazard_events_q + 32'd1;
        end
    end

    assign bus.stall_cycles  = stall_cycles_q;
    assign bus.hazard_events = hazard_events_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: WB_BYPASS=1 instance (a) and WB_BYPASS=0 instance (b).
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(32), .REG_AW(5)) ifa ();
    hazard_scoreboard_if #(.NUM_REGS(32), .REG_AW(5)) ifb ();

    hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .MAX_PENDING(3), .WB_BYPASS(1)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.slave));
    hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .MAX_PENDING(3), .WB_BYPASS(0)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.slave));

    assign ifb.id_valid = ifa.id_valid;
    assign ifb.id_instr = ifa.id_instr;
    assign ifb.wb_valid = ifa.wb_valid;
    assign ifb.wb_rd    = ifa.wb_rd;
    assign ifb.sq_valid = ifa.sq_valid;
    assign ifb.sq_rd    = ifa.sq_rd;

    typedef struct {
        string       name;
        logic        st;
        logic        is;
        logic [31:0] busy;
        logic        err;
        logic        chkb;
        logic        st_b;
        logic        chks;
        logic [31:0] sc;
        logic [31:0] he;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    localparam logic [31:0] ADDI_X5  = 32'h0010_0293;
    localparam logic [31:0] ADD_X6   = 32'h0052_8333;
    localparam logic [31:0] ADD_X7   = 32'h0063_03B3;
    localparam logic [31:0] LW_X7    = 32'h0000_A383;
    localparam logic [31:0] ADDI_X9  = 32'h0000_0493;
    localparam logic [31:0] ADDI_X0  = 32'h0050_0013;
    localparam logic [31:0] LUI_X0   = 32'h0000_1037;
    localparam logic [31:0] JAL_X0   = 32'h0000_006F;

    task automatic chk(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] want);
        tests++;
        if (act !== want) begin
            failed++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, want);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stall", 32'(ifa.stall), 32'(e.st));
                chk(e.name, "issue", 32'(ifa.issue), 32'(e.is));
                chk(e.name, "busy_mask", ifa.busy_mask, e.busy);
                chk(e.name, "err_uflow", 32'(ifa.err_uflow), 32'(e.err));
                if (e.chkb) chk(e.name, "stall_b", 32'(ifb.stall), 32'(e.st_b));
`ifdef HAZARD_STATS_EN
                if (e.chks) begin
                    chk(e.name, "stall_cycles", ifa.stall_cycles, e.sc);
                    chk(e.name, "hazard_events", ifa.hazard_events, e.he);
                end
`endif
            end
        end
    end

    task automatic step(input string name, input logic r, input logic idv, input logic [31:0] ins,
                        input logic wbv, input logic [4:0] wbrd, input logic sqv, input logic [4:0] sqrd,
                        input logic st, input logic [31:0] busy, input logic err,
                        input logic chkb = 1'b0, input logic st_b = 1'b0,
                        input logic chks = 1'b0, input logic [31:0] sc = 32'd0,
                        input logic [31:0] he = 32'd0);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        ifa.id_valid = idv;
        ifa.id_instr = ins;
        ifa.wb_valid = wbv;
        ifa.wb_rd    = wbrd;
        ifa.sq_valid = sqv;
        ifa.sq_rd    = sqrd;
        e.name = name; e.st = st; e.is = idv && !st; e.busy = busy; e.err = err;
        e.chkb = chkb; e.st_b = st_b; e.chks = chks; e.sc = sc; e.he = he;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        ifa.id_valid = 1'b0; ifa.id_instr = '0;
        ifa.wb_valid = 1'b0; ifa.wb_rd = '0;
        ifa.sq_valid = 1'b0; ifa.sq_rd = '0;
        repeat (2) @(posedge clk);

        // RAW on x5, bypass vs no bypass
        step("reset",     1, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,  0, 1, 0);
        step("t1_addi",   0, 1, ADDI_X5, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0);
        step("t1_dep0",   0, 1, ADD_X6,  0, 0, 0, 0, 1, 32'h20, 0, 1, 1);
        step("t1_dep1",   0, 1, ADD_X6,  0, 0, 0, 0, 1, 32'h20, 0, 1, 1);
        step("t1_wb",     0, 1, ADD_X6,  1, 5, 0, 0, 0, 32'h20, 0, 1, 1);
        step("t1_after",  0, 1, ADD_X6,  0, 0, 0, 0, 0, 32'h40, 0, 1, 0);
        step("t1_rst0",   1, 0, 32'h0,   0, 0, 0, 0, 0, 32'h40, 0);
        step("t1_rst1",   1, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,  0);

        // No-op encodings and x0 writes never stall or mark busy
        step("t2_nop",    0, 1, 32'h13,  0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
        step("t2_zero",   0, 1, 32'h0,   0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
        step("t2_addi0",  0, 1, ADDI_X0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
        step("t2_lui0",   0, 1, LUI_X0,  0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
        step("t2_jal0",   0, 1, JAL_X0,  0, 0, 0, 0, 0, 32'h0, 0, 1, 0);
        step("t2_idle",   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0, 0);

        // WAW saturation on x7
        step("t3_lw1",    0, 1, LW_X7, 0, 0, 0, 0, 0, 32'h0,  0);
        step("t3_lw2",    0, 1, LW_X7, 0, 0, 0, 0, 0, 32'h80, 0);
        step("t3_lw3",    0, 1, LW_X7, 0, 0, 0, 0, 0, 32'h80, 0);
        step("t3_lw4",    0, 1, LW_X7, 0, 0, 0, 0, 1, 32'h80, 0);
        step("t3_lw4wb",  0, 1, LW_X7, 1, 7, 0, 0, 1, 32'h80, 0);
        step("t3_lw4go",  0, 1, LW_X7, 0, 0, 0, 0, 0, 32'h80, 0);
        step("t3_ret1",   0, 0, 32'h0, 1, 7, 0, 0, 0, 32'h80, 0);
        step("t3_ret2",   0, 0, 32'h0, 1, 7, 0, 0, 0, 32'h80, 0);
        step("t3_ret3",   0, 0, 32'h0, 1, 7, 0, 0, 0, 32'h80, 0);
        step("t3_clear",  0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0,  0);

        // Simultaneous inc/dec on x9
        step("t4_iss",    0, 1, ADDI_X9, 0, 0, 0, 0, 0, 32'h0,   0);
        step("t4_isswb",  0, 1, ADDI_X9, 1, 9, 0, 0, 0, 32'h200, 0);
        step("t4_iss2",   0, 1, ADDI_X9, 0, 0, 0, 0, 0, 32'h200, 0);
        step("t4_wbsq",   0, 0, 32'h0,   1, 9, 1, 9, 0, 32'h200, 0);
        step("t4_zero",   0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,   0);

        // Underflow is sticky until reset
        step("t5_uflow",  0, 0, 32'h0, 1, 12, 0, 0, 0, 32'h0, 0);
        step("t5_sticky", 0, 0, 32'h0, 0, 0,  0, 0, 0, 32'h0, 1);
        step("t5_hold",   0, 0, 32'h0, 0, 0,  0, 0, 0, 32'h0, 1);
        step("t5_rst",    1, 0, 32'h0, 0, 0,  0, 0, 0, 32'h0, 1);
        step("t5_clear",  0, 0, 32'h0, 0, 0,  0, 0, 0, 32'h0, 0, 0, 0, 1, 0, 0);

        // 4-cycle stall then 2-cycle stall
        step("t6_addi",   0, 1, ADDI_X5, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0);
        step("t6_s1",     0, 1, ADD_X6,  0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 1, 0, 0);
        step("t6_s2",     0, 1, ADD_X6,  0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 1, 1, 1);
        step("t6_s3",     0, 1, ADD_X6,  0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 1, 2, 1);
        step("t6_s4",     0, 1, ADD_X6,  0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 1, 3, 1);
        step("t6_go1",    0, 1, ADD_X6,  1, 5, 0, 0, 0, 32'h20, 0, 0, 0, 1, 4, 1);
        step("t6_s5",     0, 1, ADD_X7,  0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 1, 4, 1);
        step("t6_s6",     0, 1, ADD_X7,  0, 0, 0, 0, 1, 32'h40, 0, 0, 0, 1, 5, 2);
        step("t6_go2",    0, 1, ADD_X7,  1, 6, 0, 0, 0, 32'h40, 0, 0, 0, 1, 6, 2);
        step("t6_end",    0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h80, 0, 0, 0, 1, 6, 2);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
